// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential carry-save array multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } seq_mul_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_array_mul_csa_row.sv
// One row of carry-save full-adder cells: folds a partial-product row into a sum/carry pair.
module csa_row
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] pp,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic [WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0] carry_out
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign sum_out[gi]   = pp[gi] ^ sum_in[gi] ^ carry_in[gi];
            assign carry_out[gi] = (pp[gi] & sum_in[gi]) | (pp[gi] & carry_in[gi])
                                 | (sum_in[gi] & carry_in[gi]);
        end
    endgenerate

endmodule

// File: rtl/seq_array_mul.sv
// Sequential carry-save array multiplier: one partial-product row per clock, ripple-add finish.
// Define SEQ_MUL_SIGNED_EN to enable Baugh-Wooley two's-complement products via is_signed.
module seq_array_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    seq_mul_state_e state_reg, state_next;

    logic [WIDTH-1:0]   x_reg, y_reg;
    logic [WIDTH-1:0]   sum_reg, carry_reg, lo_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic               accept;
    logic               last_row;
    logic [WIDTH-1:0]   pp, row_s, row_c, hi_sum;

    assign last_row = (cnt_reg == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
        accept     = in_valid && in_ready;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_row) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (out_ready) state_next = in_valid ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef SEQ_MUL_SIGNED_EN
    logic signed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      signed_reg <= 1'b0;
        else if (accept) signed_reg <= is_signed;
    end

    // Baugh-Wooley: NAND the sign-weighted cells, then add 2^W + 2^(2W-1) in the high half.
    always_comb begin
        pp = x_reg & {WIDTH{y_reg[cnt_reg]}};
        if (signed_reg) begin
            if (last_row) pp[WIDTH-2:0] = ~pp[WIDTH-2:0];
            else          pp[WIDTH-1]   = ~pp[WIDTH-1];
        end
    end

    assign hi_sum = sum_reg + carry_reg
                  + (signed_reg ? (WIDTH'(1) | (WIDTH'(1) << (WIDTH-1))) : '0);
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    assign pp     = x_reg & {WIDTH{y_reg[cnt_reg]}};
    assign hi_sum = sum_reg + carry_reg;
`endif

    csa_row #(.WIDTH(WIDTH)) u_row (
        .pp        (pp),
        .sum_in    (sum_reg),
        .carry_in  (carry_reg),
        .sum_out   (row_s),
        .carry_out (row_c)
    );

    // Sum moves down one weight per row; carry already sits one weight up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg       <= '0;
            y_reg       <= '0;
            sum_reg     <= '0;
            carry_reg   <= '0;
            lo_reg      <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else if (accept) begin
            x_reg     <= x;
            y_reg     <= y;
            sum_reg   <= '0;
            carry_reg <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg         <= {1'b0, row_s[WIDTH-1:1]};
            carry_reg       <= row_c;
            lo_reg[cnt_reg] <= row_s[0];
            cnt_reg         <= cnt_reg + CNT_W'(1);
        end else if (state_reg == FINAL) begin
            product_reg <= {hi_sum, lo_reg};
        end
    end

    assign product   = product_reg;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN) || (state_reg == FINAL);

endmodule

// File: doc/seq_array_mul.md
Name: seq_array_mul

Overview:
- Parametrised sequential carry-save array multiplier.
- Processes one partial-product row of WIDTH bit cells per clock, instead of a full combinational array.
- Valid/ready handshakes on input and output; resolves the final carry with one ripple-add cycle.
- Used as the multiply datapath element wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the row counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present on x/y.
- in_ready  output  1  block can accept operands this cycle.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- is_signed  input  1  two's-complement request; used only with SEQ_MUL_SIGNED_EN.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result.
- busy  output  1  high in RUN or FINAL.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; all datapath registers cleared.
  - out_valid=0, product=0, busy=0, in_ready=1.
- State machine IDLE, RUN, FINAL, DONE:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready: capture x, y and is_signed; clear sum/carry registers; cnt=0; go to RUN.
  - RUN: each edge feeds row x&{WIDTH{y[cnt]}} with stored sum/carry into the row of bit cells.
    - Per cell: s = pp^si^ci; co = majority(pp,si,ci).
    - Row LSB shifts into the low product half, bit cnt.
    - Sum shifts right one; carry stays aligned.
    - cnt++. When cnt==WIDTH-1, go to FINAL after that edge.
  - FINAL: one edge; ripple-add the sum and carry vectors into the high product half; go to DONE.
  - DONE: out_valid=1, product stable. On out_valid&&out_ready, leave DONE.
- Latency: out_valid rises WIDTH+1 edges after the accepting edge. WIDTH=8 gives 9 cycles.
- Throughput: one operation per WIDTH+2 cycles with back-to-back handshakes.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
  - A simultaneous output and input handshake in DONE goes directly to RUN with new operands.
  - out_valid drops on that same edge.
- out_valid is never asserted except in DONE.
- product holds its last value in IDLE, RUN and FINAL. Consumers sample it only while out_valid=1.
- x, y and is_signed are ignored outside the accepting edge; changes during RUN have no effect.
- in_valid may drop without being accepted; there is no obligation to hold it.
- Backpressure: DONE holds indefinitely while out_ready=0.
- rst_n low mid-operation aborts immediately. No partial result is emitted, and no out_valid pulse follows release.
- Arithmetic is exact modulo 2^(2*WIDTH); there is no overflow condition.

Optional Feature:
- SEQ_MUL_SIGNED_EN defined:
  - is_signed is captured at accept.
  - When it is 1, use Baugh-Wooley: invert the MSB partial-product bit of rows 0..WIDTH-2 and the non-MSB bits of the last row. Add correction 2^WIDTH + 2^(2*WIDTH-1) in FINAL.
  - product is then the two's-complement x*y.
  - Latency is unchanged.
- SEQ_MUL_SIGNED_EN undefined: is_signed is ignored; all operations are unsigned. Port list is identical in both builds.

Decomposition:
- Package seq_mul_pkg:
  - state enum typedef (IDLE, RUN, FINAL, DONE), 2-bit encoding.
  - localparam helper for CNT_W.
- Sub-module csa_row (combinational, parameter WIDTH):
  - Inputs: partial-product row, sum-in, carry-in.
  - Outputs: sum-out, carry-out.
  - One generate loop of bit cells.
- Top: FSM, counter, shift registers, final ripple adder.

Test Plan:
- WIDTH=8, x=13, y=11, out_ready=1 -> product=143 (0x008F), out_valid exactly 9 cycles after accept, busy high during RUN/FINAL.
- x=255, y=255 -> 65025 (0xFE01); x=0, y=200 -> 0; x=1, y=1 -> 1.
- Hold out_ready=0 for 20 cycles after 100*3:
  - out_valid stays 1, product=300 stable, in_ready=0.
  - Then raise out_ready with in_valid=1 carrying 7*6 -> next product 42, no idle cycle.
- Pulse rst_n low at RUN cnt=4 of 200*200:
  - All outputs reset immediately; no out_valid afterwards.
  - Next operation 9*9 yields 81.
- Change x/y every cycle during RUN of 17*19 -> product=323, unaffected.
- With SEQ_MUL_SIGNED_EN, is_signed=1:
  - x=0xFD (-3), y=5 -> 0xFFF1 (-15).
  - x=0x80, y=0x80 -> 0x4000.
  - Same operands with is_signed=0 -> 0x04F1 and 0x4000.
